// File: rtl/vga_card_pkg.sv
// Shared constants, FSM encoding and shadow-entry layout for the VGA card fetch path.
package vga_card_pkg;

  localparam int unsigned NUM_SLOTS  = 10;
  localparam int unsigned BASE_ADDR  = 16;
  localparam int unsigned CARD_COUNT = 52;
  localparam int unsigned IDX_WIDTH  = 6;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SLOT_WIDTH = 4;
  localparam int unsigned OVR_WIDTH  = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] SWAP  = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic [IDX_WIDTH-1:0] index;
  } shadow_entry_t;

  // Convert a raw RAM word into a shadow entry; out-of-deck values mark an empty slot.
  function automatic shadow_entry_t make_entry(input logic [DATA_WIDTH-1:0] word);
    shadow_entry_t e;
    e.index = word[IDX_WIDTH-1:0];
    e.valid = (word < DATA_WIDTH'(CARD_COUNT));
    return e;
  endfunction

endpackage

// File: rtl/card_shadow_buffer.sv
// Double-buffered per-slot card table: fetch writes the back bank, renderer reads the front bank.
module card_shadow_buffer
  import vga_card_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [SLOT_WIDTH-1:0] wr_slot,
  input  logic [IDX_WIDTH-1:0]  wr_index,
  input  logic                  wr_valid,
  input  logic                  swap,
  input  logic                  clear,
  input  logic [SLOT_WIDTH-1:0] rd_slot,
  output logic [IDX_WIDTH-1:0]  rd_index,
  output logic                  rd_valid
);

  shadow_entry_t bank_q [2][NUM_SLOTS];
  shadow_entry_t bank_d [2][NUM_SLOTS];
  logic          front_q, front_d;
  shadow_entry_t rd_q, rd_d;

  // Back-bank clear/write, bank swap and registered front-bank lookup.
  always_comb begin
    bank_d  = bank_q;
    front_d = front_q;
    rd_d    = '0;
    if (clear) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        bank_d[~front_q][i] = '0;
      end
    end
    if (wr_en && (wr_slot < SLOT_WIDTH'(NUM_SLOTS))) begin
      bank_d[~front_q][wr_slot] = '{valid: wr_valid, index: wr_index};
    end
    if (swap) begin
      front_d = ~front_q;
    end
    if (rd_slot < SLOT_WIDTH'(NUM_SLOTS)) begin
      rd_d = bank_q[front_q][rd_slot];
    end
  end

  // Storage flops; reset empties both banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q  <= '{default: '0};
      front_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      bank_q  <= bank_d;
      front_q <= front_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_index = rd_q.index;
  assign rd_valid = rd_q.valid;

endmodule

// File: rtl/vga_card_fetch_arbiter.sv
// Shares the data-RAM read port between the CPU and a once-per-frame card-slot fetch.
module vga_card_fetch_arbiter
  import vga_card_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  screenEnd,
  input  logic                  active,
  input  logic [3:0]            slot_sel,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [IDX_WIDTH-1:0]  card_index,
  output logic                  card_valid,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  logic [1:0]            state_q, state_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic                  own_cpu_q, own_cpu_d;
  logic                  own_fetch_q, own_fetch_d;
  logic [SLOT_WIDTH-1:0] tag_q, tag_d;
  logic [OVR_WIDTH-1:0]  overrun_q, overrun_d;

  logic                  fetch_issue;
  logic                  buf_swap;
  logic                  buf_clear;
  logic [1:0]            ovr_inc;
  logic [OVR_WIDTH:0]    ovr_sum;
  shadow_entry_t         wr_entry;

  // Fetch FSM, slot counter and overrun accounting.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    fetch_issue = 1'b0;
    buf_swap    = 1'b0;
    buf_clear   = 1'b0;
    ovr_inc     = 2'd0;
    case (state_q)
      IDLE: begin
        if (screenEnd) begin
          state_d   = FETCH;
          slot_d    = '0;
          buf_clear = 1'b1;
        end
      end
      FETCH: begin
        if (!cpu_rd_req) begin
          fetch_issue = 1'b1;
          slot_d      = slot_q + 4'd1;
          if (slot_q == SLOT_WIDTH'(NUM_SLOTS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = SWAP;
        // Fetch finished after blanking ended: the swap will be late.
        if (active) begin
          ovr_inc = ovr_inc + 2'd1;
        end
      end
      SWAP: begin
        if (!active) begin
          buf_swap = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame boundary while still busy means that frame's fetch is skipped.
    if (screenEnd && (state_q != IDLE)) begin
      ovr_inc = ovr_inc + 2'd1;
    end
    ovr_sum   = {1'b0, overrun_q} + 9'(ovr_inc);
    overrun_d = ovr_sum[OVR_WIDTH] ? {OVR_WIDTH{1'b1}} : ovr_sum[OVR_WIDTH-1:0];
  end

  // Owner/tag pipeline travels with each issued read to route its return.
  always_comb begin
    own_cpu_d   = cpu_rd_req;
    own_fetch_d = fetch_issue;
    tag_d       = fetch_issue ? slot_q : tag_q;
  end

  // State flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      own_cpu_q   <= 1'b0;
      own_fetch_q <= 1'b0;
      tag_q       <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      own_cpu_q   <= own_cpu_d;
      own_fetch_q <= own_fetch_d;
      tag_q       <= tag_d;
      overrun_q   <= overrun_d;
    end
  end

  // CPU wins the port outright; the fetcher only uses otherwise idle cycles.
  assign mem_rd_en = cpu_rd_req | fetch_issue;
  assign mem_addr  = cpu_rd_req  ? cpu_addr :
                     fetch_issue ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(slot_q)) :
                                   '0;

  assign cpu_rvalid  = own_cpu_q;
  assign cpu_rdata   = own_cpu_q ? mem_rdata : '0;
  assign busy        = (state_q != IDLE);
  assign overrun_cnt = overrun_q;
  assign wr_entry    = make_entry(mem_rdata);

  card_shadow_buffer u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (own_fetch_q),
    .wr_slot  (tag_q),
    .wr_index (wr_entry.index),
    .wr_valid (wr_entry.valid),
    .swap     (buf_swap),
    .clear    (buf_clear),
    .rd_slot  (slot_sel),
    .rd_index (card_index),
    .rd_valid (card_valid)
  );

endmodule

// File: tb/tb_vga_card_fetch_arbiter.sv
// Directed bench for vga_card_fetch_arbiter with a one-cycle-latency RAM model.
module tb_vga_card_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        screen_end;
  logic        active;
  logic [3:0]  slot_sel;
  logic        cpu_rd_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [5:0]  card_index;
  logic        card_valid;
  logic        busy;
  logic [7:0]  overrun_cnt;

  logic [31:0] ram [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Synchronous RAM: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[7:0]];
  end

  vga_card_fetch_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .screenEnd   (screen_end),
    .active      (active),
    .slot_sel    (slot_sel),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_addr    (cpu_addr),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .card_index  (card_index),
    .card_valid  (card_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 60 && busy; n++) tick();
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic run_fetch(input string tag);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    wait_idle(tag);
  endtask

  task automatic read_slot(input string tag, input logic [3:0] s,
                           input logic [5:0] exp_idx, input logic exp_vld);
    slot_sel = s;
    tick();
    check({tag, "_idx"}, 32'(card_index), 32'(exp_idx));
    check({tag, "_vld"}, 32'(card_valid), 32'(exp_vld));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    for (int i = 0; i < 10; i++) ram[16 + i] = 32'(i);
    ram[100]   = 32'h0000_abcd;
    mem_rdata  = 32'h0;
    reset      = 1'b1;
    screen_end = 1'b0;
    active     = 1'b0;
    slot_sel   = 4'd0;
    cpu_rd_req = 1'b0;
    cpu_addr   = 32'h0;
    tick();
    tick();

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    check("rst_idx", 32'(card_index), 32'd0);
    check("rst_vld", 32'(card_valid), 32'd0);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rden", 32'(mem_rd_en), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // 1: idle CPU, addresses 16..25 on consecutive cycles.
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t1_rden", 32'(mem_rd_en), 32'd1);
      check("t1_addr", mem_addr, 32'(16 + i));
      tick();
    end
    check("t1_drain_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("t1_idle", 32'(busy), 32'd0);
    read_slot("t1_slot3", 4'd3, 6'd3, 1'b1);
    for (int i = 0; i < 10; i++) read_slot("t1_all", 4'(i), 6'(i), 1'b1);

    // 2: out-of-deck value and out-of-range slot.
    ram[20] = 32'd60;
    run_fetch("t2_done");
    read_slot("t2_slot4", 4'd4, 6'd60, 1'b0);
    read_slot("t2_slot12", 4'd12, 6'd0, 1'b0);
    ram[20] = 32'd4;

    // 3: five CPU reads in the middle of a fetch.
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    tick();
    tick();
    tick();
    cpu_rd_req = 1'b1;
    cpu_addr   = 32'd100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_cpu_addr", mem_addr, 32'd100);
      tick();
      check("t3_rvalid", 32'(cpu_rvalid), 32'd1);
      check("t3_rdata", cpu_rdata, 32'h0000_abcd);
    end
    cpu_rd_req = 1'b0;
    #1;
    check("t3_resume_addr", mem_addr, 32'd19);
    wait_idle("t3_done");
    for (int i = 0; i < 10; i++) read_slot("t3_all", 4'(i), 6'(i), 1'b1);

    // 4: fetch runs into active video; second screenEnd while busy.
    for (int i = 0; i < 10; i++) ram[16 + i] = 32'(9 - i);
    slot_sel   = 4'd1;
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    cpu_rd_req = 1'b1;
    cpu_addr   = 32'd100;
    tick();
    tick();
    tick();
    active     = 1'b1;
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    check("t4_ovr1", 32'(overrun_cnt), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    cpu_rd_req = 1'b0;
    repeat (15) tick();
    check("t4_ovr2", 32'(overrun_cnt), 32'd2);
    check("t4_wait_swap", 32'(busy), 32'd1);
    check("t4_front_held", 32'(card_index), 32'd1);
    active = 1'b0;
    tick();
    tick();
    check("t4_swapped_idx", 32'(card_index), 32'd8);
    check("t4_idle", 32'(busy), 32'd0);

    // 5: reset in the middle of a fetch.
    for (int i = 0; i < 10; i++) ram[16 + i] = 32'(i);
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ovr", 32'(overrun_cnt), 32'd0);
    check("t5_rden", 32'(mem_rd_en), 32'd0);
    check("t5_addr", mem_addr, 32'd0);
    check("t5_idx", 32'(card_index), 32'd0);
    check("t5_vld", 32'(card_valid), 32'd0);
    check("t5_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    read_slot("t5_cleared", 4'd3, 6'd0, 1'b0);
    run_fetch("t5_done");
    read_slot("t5_slot5", 4'd5, 6'd5, 1'b1);
    read_slot("t5_slot9", 4'd9, 6'd9, 1'b1);

    // 6: screenEnd together with a CPU read.
    cpu_rd_req = 1'b1;
    cpu_addr   = 32'd100;
    screen_end = 1'b1;
    #1;
    check("t6_cpu_first", mem_addr, 32'd100);
    tick();
    cpu_rd_req = 1'b0;
    screen_end = 1'b0;
    #1;
    check("t6_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t6_fetch_addr", mem_addr, 32'd16);
    check("t6_busy", 32'(busy), 32'd1);
    wait_idle("t6_done");
    read_slot("t6_slot0", 4'd0, 6'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
